// File: rtl/int_to_fp_pipe.sv
// int_to_fp_pipe: handshaked integer to floating-point converter.
// One operand at a time walks IDLE -> NORM -> RND -> OUT, one state per cycle.
// Optional feature macro INT_TO_FP_RM_EN: when defined the rm port selects the
// rounding mode; when undefined rm is ignored and every conversion uses RNE.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both 1. in_ready is high only in IDLE (and never during or directly out of
// reset); out_valid is high only in OUT, and fp/inexact/overflow stay constant
// from the rise of out_valid until the output transfer completes.
module int_to_fp_pipe #(
  parameter int int_size      = 32,
  parameter int exponent_size = 8,
  parameter int mantissa_size = 23,
  parameter int exp_bias      = (1 << (exponent_size - 1)) - 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [int_size-1:0]                  int_data,
  input  logic                                 is_signed,
  input  logic [1:0]                           rm,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [exponent_size+mantissa_size:0] fp,
  output logic                                 inexact,
  output logic                                 overflow,
  output logic [1:0]                           state_dbg
);

  // Exponent math is one bit wider than the field so overflow cannot wrap.
  localparam int ew = exponent_size + 1;
  localparam int pw = $clog2(int_size);
  // Normalised value below the leading one, padded so fraction, guard and
  // sticky always exist even when no bits are discarded.
  localparam int xw = int_size + mantissa_size + 1;
  localparam int fw = exponent_size + mantissa_size + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    RND  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic                alive;
  logic                accept;
  logic                acc_sign;
  logic [int_size-1:0] acc_mag;
  logic                sign_q;
  logic [int_size-1:0] mag_q;
  logic [int_size-1:0] norm_q;
  logic [ew-1:0]       e_q;
  logic [1:0]          mode;

  logic [pw-1:0]          lead;
  logic [pw-1:0]          sh;
  logic [int_size-1:0]    norm_c;
  logic [ew-1:0]          e_c;
  logic                   zero;
  logic [xw-1:0]          ext;
  logic [mantissa_size-1:0] frac;
  logic                   guard;
  logic                   sticky;
  logic                   rnd_up;
  logic [mantissa_size:0] frac_sum;
  logic [ew-1:0]          e_r;
  logic                   ovf_c;
  logic                   to_inf;
  logic [fw-1:0]          fp_c;
  logic                   inexact_c;

`ifdef INT_TO_FP_RM_EN
  logic [1:0] rm_q;
  // Rounding mode travels with the operand it was presented with.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rm_q <= 2'b00;
    else if (accept) rm_q <= rm;
  end
  assign mode = rm_q;
`else
  logic unused_rm;
  assign unused_rm = ^rm;
  assign mode      = 2'b00;
`endif

  assign in_ready  = alive && (state == IDLE);
  assign out_valid = (state == OUT);
  assign accept    = in_valid && in_ready;
  assign state_dbg = state;

  // Holds in_ready low until the first edge after reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: fixed three-cycle walk, then wait for the consumer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = NORM;
      NORM:    state_nxt = RND;
      RND:     state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture: sign and unsigned magnitude (most-negative maps to 2^(n-1)).
  always_comb begin
    acc_sign = is_signed & int_data[int_size-1];
    acc_mag  = acc_sign ? (~int_data) + int_size'(1) : int_data;
  end

  // Normalise: priority-encode the leading one and shift it to the MSB.
  always_comb begin
    lead = '0;
    for (int i = 0; i < int_size; i++) begin
      if (mag_q[i]) lead = pw'(i);
    end
    sh     = pw'(int_size - 1) - lead;
    norm_c = mag_q << sh;
    e_c    = ew'(exp_bias) + ew'(lead);
  end

  // Round: a zero operand is recognised by the missing leading one.
  always_comb begin
    zero   = ~norm_q[int_size-1];
    ext    = {norm_q[int_size-2:0], {(mantissa_size + 2){1'b0}}};
    frac   = ext[xw-1 -: mantissa_size];
    guard  = ext[xw-1-mantissa_size];
    sticky = |ext[xw-2-mantissa_size:0];
    case (mode)
      2'b00:   rnd_up = guard & (sticky | frac[0]);
      2'b01:   rnd_up = 1'b0;
      2'b10:   rnd_up = sign_q & (guard | sticky);
      default: rnd_up = ~sign_q & (guard | sticky);
    endcase
    frac_sum = {1'b0, frac} + (mantissa_size + 1)'(rnd_up);
    e_r      = frac_sum[mantissa_size] ? e_q + ew'(1) : e_q;
    ovf_c    = ~zero & (e_r >= ew'((1 << exponent_size) - 1));
    to_inf   = (mode == 2'b00) | ((mode == 2'b11) & ~sign_q) | ((mode == 2'b10) & sign_q);
    if (zero) begin
      fp_c      = '0;
      inexact_c = 1'b0;
    end else if (ovf_c) begin
      fp_c      = to_inf ? {sign_q, {exponent_size{1'b1}}, {mantissa_size{1'b0}}}
                         : {sign_q, {(exponent_size - 1){1'b1}}, 1'b0, {mantissa_size{1'b1}}};
      inexact_c = 1'b1;
    end else begin
      fp_c      = {sign_q, e_r[exponent_size-1:0], frac_sum[mantissa_size-1:0]};
      inexact_c = guard | sticky;
    end
  end

  // Datapath registers, each loaded in the state that produces it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sign_q   <= 1'b0;
      mag_q    <= '0;
      norm_q   <= '0;
      e_q      <= '0;
      fp       <= '0;
      inexact  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sign_q <= acc_sign;
          mag_q  <= acc_mag;
        end
        NORM: begin
          norm_q <= norm_c;
          e_q    <= e_c;
        end
        RND: begin
          fp       <= fp_c;
          inexact  <= inexact_c;
          overflow <= ovf_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_fp_pipe.sv
// tb_int_to_fp_pipe: directed vectors for a binary32 instance (a_*) and a
// 5/10-bit instance (h_*), checked against an arithmetic reference model and
// against hand-computed literals.
module tb_int_to_fp_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_in_valid, a_in_ready, a_is_signed, a_out_valid, a_out_ready;
  logic        a_inexact, a_overflow;
  logic [31:0] a_int, a_fp;
  logic [1:0]  a_rm, a_state_unused;
  logic        h_in_valid, h_in_ready, h_is_signed, h_out_valid, h_out_ready;
  logic        h_inexact, h_overflow;
  logic [31:0] h_int;
  logic [15:0] h_fp;
  logic [1:0]  h_rm, h_state_unused;

  int tests = 0;
  int fails = 0;
  logic [33:0] a_exp_q[$];
  logic [33:0] h_exp_q[$];
  logic [33:0] got;
  int          lat;

  int_to_fp_pipe u_a (
    .clk(clk), .reset(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .int_data(a_int), .is_signed(a_is_signed), .rm(a_rm), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .fp(a_fp), .inexact(a_inexact), .overflow(a_overflow),
    .state_dbg(a_state_unused)
  );

  int_to_fp_pipe #(.int_size(32), .exponent_size(5), .mantissa_size(10)) u_h (
    .clk(clk), .reset(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .int_data(h_int), .is_signed(h_is_signed), .rm(h_rm), .out_valid(h_out_valid),
    .out_ready(h_out_ready), .fp(h_fp), .inexact(h_inexact), .overflow(h_overflow),
    .state_dbg(h_state_unused)
  );

  // ---------------- reference model ----------------
  // Returns {overflow, inexact, fp} from plain integer arithmetic.
  function automatic logic [33:0] model(input logic [31:0] v, input logic sg,
                                        input logic [1:0] m, input int es, input int ms);
    longint mag, q, rem, half, e, emax, r;
    int     p, sh;
    logic   s, up, inx, ovf, inf;
    logic [1:0] md;
`ifdef INT_TO_FP_RM_EN
    md = m;
`else
    md = 2'b00;
`endif
    s   = sg & v[31];
    mag = s ? (longint'(1) << 32) - longint'({32'h0, v}) : longint'({32'h0, v});
    if (mag == 0) return '0;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    sh = p - ms;
    if (sh > 0) begin
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = longint'(1) << (sh - 1);
    end else begin
      q    = mag << (-sh);
      rem  = 0;
      half = 1;
    end
    inx = (rem != 0);
    case (md)
      2'b00:   up = (rem > half) || (rem == half && q[0]);
      2'b01:   up = 1'b0;
      2'b10:   up = s && inx;
      default: up = !s && inx;
    endcase
    q = q + (up ? 1 : 0);
    if (q == (longint'(1) << (ms + 1))) begin
      q = q >> 1;
      p++;
    end
    e    = ((longint'(1) << (es - 1)) - 1) + p;
    emax = (longint'(1) << es) - 1;
    ovf  = (e >= emax);
    if (ovf) begin
      inx = 1'b1;
      inf = (md == 0) || (md == 3 && !s) || (md == 2 && s);
      if (inf) r = emax << ms;
      else     r = ((emax - 1) << ms) | ((longint'(1) << ms) - 1);
    end else begin
      r = (e << ms) | (q - (longint'(1) << ms));
    end
    r = r | (longint'(s) << (es + ms));
    return {ovf, inx, r[31:0]};
  endfunction

  function automatic logic [33:0] rd(input bit h);
    return h ? {h_overflow, h_inexact, 16'h0, h_fp} : {a_overflow, a_inexact, a_fp};
  endfunction

  task automatic check(input string name, input logic [33:0] g, input logic [33:0] e);
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, g, e);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Expected results enter at input transfer and leave at output transfer.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_exp_q.delete();
      h_exp_q.delete();
    end else begin
      if (a_in_valid && a_in_ready) a_exp_q.push_back(model(a_int, a_is_signed, a_rm, 8, 23));
      if (a_out_valid && a_out_ready && a_exp_q.size() > 0) void'(a_exp_q.pop_front());
      if (h_in_valid && h_in_ready) h_exp_q.push_back(model(h_int, h_is_signed, h_rm, 5, 10));
      if (h_out_valid && h_out_ready && h_exp_q.size() > 0) void'(h_exp_q.pop_front());
    end
  end

  // Compare every cycle a result is being offered.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_out_valid) begin
        if (a_exp_q.size() == 0) check("a_spurious_out_valid", 34'd1, 34'd0);
        else                     check("a_result", rd(1'b0), a_exp_q[0]);
      end
      if (h_out_valid) begin
        if (h_exp_q.size() == 0) check("h_spurious_out_valid", 34'd1, 34'd0);
        else                     check("h_result", rd(1'b1), h_exp_q[0]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic set_in(input bit h, input logic vld, input logic [31:0] v,
                        input logic sg, input logic [1:0] m);
    if (h) begin h_in_valid = vld; h_int = v; h_is_signed = sg; h_rm = m; end
    else   begin a_in_valid = vld; a_int = v; a_is_signed = sg; a_rm = m; end
  endtask

  task automatic set_oready(input bit h, input logic r);
    if (h) h_out_ready = r;
    else   a_out_ready = r;
  endtask

  // One conversion; hold = cycles to keep out_ready low once out_valid is up.
  task automatic xfer(input bit h, input logic [31:0] v, input logic sg,
                      input logic [1:0] m, input int hold);
    int n;
    @(negedge clk);
    set_in(h, 1'b1, v, sg, m);
    set_oready(h, hold == 0);
    n = 0;
    while (!(h ? h_in_ready : a_in_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 34'(n < 20), 34'd1);
    @(posedge clk);
    @(negedge clk);
    // Operand changes after acceptance must not matter.
    set_in(h, 1'b0, $urandom(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    lat = 1;
    while (!(h ? h_out_valid : a_out_valid) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency_edges", 34'(lat), 34'd3);
    got = rd(h);
    for (int i = 0; i < hold; i++) begin
      check("bp_in_ready_low", 34'(h ? h_in_ready : a_in_ready), 34'd0);
      check("bp_out_valid_high", 34'(h ? h_out_valid : a_out_valid), 34'd1);
      check("bp_result_stable", rd(h), got);
      set_in(h, 1'b1, $urandom(), 1'b0, 2'b00);
      @(negedge clk);
    end
    set_in(h, 1'b0, 32'h0, 1'b0, 2'b00);
    set_oready(h, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("idle_return", h ? {32'h0, h_in_ready, h_out_valid} : {32'h0, a_in_ready, a_out_valid},
          34'b10);
  endtask

  task automatic vec(input bit h, input logic [31:0] v, input logic sg,
                     input logic [1:0] m, input logic [33:0] e, input string name);
    xfer(h, v, sg, m, 0);
    check(name, got, e);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 2'b00);
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 2'b00);
    a_out_ready = 1'b1;
    h_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {1'b0, a_in_ready, a_out_valid, a_overflow, a_inexact, a_fp}, 34'd0);
    check("reset_outputs_h", {17'h0, h_in_ready, h_out_valid, h_overflow, h_inexact, h_fp}, 34'd0);
    rst_n = 1'b1;
    #1;
    check("in_ready_before_first_edge", 34'(a_in_ready), 34'd0);
    @(negedge clk);
    check("in_ready_after_first_edge", 34'(a_in_ready), 34'd1);

    // Model pinned against hand-computed values.
    check("model_pin_one", model(32'h1, 1'b1, 2'b00, 8, 23), {2'b00, 32'h3F800000});
    check("model_pin_half_ovf", model(32'd70000, 1'b0, 2'b00, 5, 10), {2'b11, 32'h00007C00});

    vec(1'b0, 32'h00000001, 1'b1, 2'b00, {2'b00, 32'h3F800000}, "s_one");
    vec(1'b0, 32'hFFFFFFFF, 1'b1, 2'b00, {2'b00, 32'hBF800000}, "s_minus_one");
    vec(1'b0, 32'h80000000, 1'b1, 2'b00, {2'b00, 32'hCF000000}, "s_most_negative");
    vec(1'b0, 32'hFFFFFFFF, 1'b0, 2'b00, {2'b01, 32'h4F800000}, "u_all_ones_carry");
    vec(1'b0, 32'h00000000, 1'b0, 2'b00, {2'b00, 32'h00000000}, "u_zero");
    vec(1'b0, 32'h00000000, 1'b1, 2'b00, {2'b00, 32'h00000000}, "s_zero_positive");
    vec(1'b0, 32'h7FFFFFFF, 1'b1, 2'b00, {2'b01, 32'h4F000000}, "s_max_rounds_up");
    vec(1'b0, 32'h01000001, 1'b0, 2'b00, {2'b01, 32'h4B800000}, "rne_tie_even");
    vec(1'b0, 32'h01000003, 1'b0, 2'b00, {2'b01, 32'h4B800002}, "rne_tie_odd_up");
    vec(1'b0, 32'h01000001, 1'b0, 2'b01, {2'b01, 32'h4B800000}, "rtz");
`ifdef INT_TO_FP_RM_EN
    vec(1'b0, 32'h01000001, 1'b0, 2'b11, {2'b01, 32'h4B800001}, "rup_pos");
    vec(1'b0, 32'hFEFFFFFF, 1'b1, 2'b10, {2'b01, 32'hCB800001}, "rdn_neg");
    vec(1'b1, 32'd70000,    1'b0, 2'b01, {2'b11, 32'h00007BFF}, "h_rtz_ovf_max");
    vec(1'b1, 32'hFFFEEE90, 1'b1, 2'b11, {2'b11, 32'h0000FBFF}, "h_rup_neg_ovf_max");
`else
    vec(1'b0, 32'h01000001, 1'b0, 2'b11, {2'b01, 32'h4B800000}, "rup_ignored");
    vec(1'b0, 32'hFEFFFFFF, 1'b1, 2'b10, {2'b01, 32'hCB800000}, "rdn_ignored");
    vec(1'b1, 32'd70000,    1'b0, 2'b01, {2'b11, 32'h00007C00}, "h_rtz_ignored_inf");
    vec(1'b1, 32'hFFFEEE90, 1'b1, 2'b11, {2'b11, 32'h0000FC00}, "h_rup_ignored_ninf");
`endif
    vec(1'b1, 32'd70000,    1'b0, 2'b00, {2'b11, 32'h00007C00}, "h_rne_ovf_inf");
    vec(1'b1, 32'hFFFEEE90, 1'b1, 2'b10, {2'b11, 32'h0000FC00}, "h_rdn_neg_inf");
    vec(1'b1, 32'h00000001, 1'b0, 2'b00, {2'b00, 32'h00003C00}, "h_one");
    vec(1'b1, 32'hFFFFF800, 1'b1, 2'b00, {2'b00, 32'h0000E800}, "h_minus_2048");

    // Backpressure: hold the result for 10 cycles while junk is offered.
    xfer(1'b0, 32'h00000003, 1'b0, 2'b00, 10);
    check("bp_value", got, {2'b00, 32'h40400000});
    check("bp_no_extra_accept", 34'(a_exp_q.size()), 34'd0);

    // Reset during NORM: everything clears at once, no result escapes.
    @(negedge clk);
    set_in(1'b0, 1'b1, 32'd12345, 1'b0, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_reset_clear", {1'b0, a_in_ready, a_out_valid, a_overflow, a_inexact, a_fp}, 34'd0);
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("no_result_after_abort", 34'(a_out_valid), 34'd0);
    end
    vec(1'b0, 32'd100, 1'b0, 2'b00, {2'b00, 32'h42C80000}, "after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
